// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between instruction fetch and
//               data memory; DM wins by default, a starvation counter forces IF.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                 c_CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner_dm;
    logic [c_CNT_W-1:0]  r_starve;
    logic                r_drop;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;

    logic                w_launch;
    logic                w_grant;
    logic                w_if_win;
    logic                w_if_ready;
    logic                w_dm_ready;

    assign w_if_win = if_req & (~dm_req | (r_starve == c_STARVE_MAX));
    // Launch is combinational in IDLE; masking with reset keeps outputs at zero during reset.
    assign w_grant  = w_launch & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_if_ready  = 1'b0;
        w_dm_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (if_req | dm_req) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                w_dm_ready  = r_owner_dm;
                w_if_ready  = ~r_owner_dm & ~r_drop & ~if_flush;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem_req   = w_grant;
    assign mem_we    = w_grant ? (~w_if_win & dm_we) : r_we;
    assign mem_addr  = w_grant ? (w_if_win ? if_addr : dm_addr) : r_addr;
    assign mem_wdata = w_grant ? (w_if_win ? '0 : dm_wdata) : r_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner_dm <= 1'b1;
            r_starve   <= '0;
            r_drop     <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_owner_dm <= ~w_if_win;
                r_we       <= mem_we;
                r_addr     <= mem_addr;
                r_wdata    <= mem_wdata;
                if (w_if_win) begin
                    r_starve <= '0;
                end else if (if_req && (r_starve != c_STARVE_MAX)) begin
                    r_starve <= r_starve + 1'b1;
                end
            end
            if ((r_state == S_WAIT) && mem_rvalid) begin
                if (r_owner_dm) begin
                    r_dm_rdata <= mem_rdata;
                end else begin
                    r_if_rdata <= mem_rdata;
                end
            end
            // A flush in the completion cycle still drops the fetch.
            if ((r_state == S_WAIT) && if_flush && !r_owner_dm) begin
                r_drop <= 1'b1;
            end else if (r_state == S_RESP) begin
                r_drop <= 1'b0;
            end
        end
    end

    assign if_ready = w_if_ready;
    assign dm_ready = w_dm_ready;
    assign if_rdata = r_if_rdata;
    assign dm_rdata = r_dm_rdata;

endmodule
`default_nettype wire
